// File: rtl/mem_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_stage                                                              |
// | Memory-access pipeline stage: word load/store over a single-outstanding |
// | req/ack bus, misalignment detection, and the MEM pipeline register.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [29:0] EXPC,
  input  logic        EXEn,
  input  logic        EXBrFlag,
  input  logic [1:0]  EXMemOp,
  input  logic [31:0] EXMemWrData,
  input  logic [1:0]  EXCtrlOp,
  input  logic [4:0]  EXDstAddr,
  input  logic        EXGPRWE_,
  input  logic [2:0]  EXExpCode,
  input  logic [31:0] EXOut,
  output logic        MemReq,
  output logic        MemWE,
  output logic [29:0] MemAddr,
  output logic [31:0] MemWrData,
  input  logic        MemAck,
  input  logic [31:0] MemRdData,
  output logic        Busy,
  output logic [29:0] MEMPC,
  output logic        MEMEn,
  output logic        MEMBrFlag,
  output logic [1:0]  MEMCtrlOp,
  output logic [4:0]  MEMDstAddr,
  output logic        MEMGPRWE_,
  output logic [2:0]  MEMExpCode,
  output logic [31:0] MEMOut
);

  localparam logic [1:0] C_OP_LDW  = 2'd1;
  localparam logic [1:0] C_OP_STW  = 2'd2;
  localparam logic [2:0] C_EXC_MIS = 3'd4;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_flush_pend;
  logic        r_hold_valid;
  logic [31:0] r_hold_data;

  logic        w_is_ldw;
  logic        w_is_stw;
  logic        w_mem_op;
  logic        w_mis;
  logic        w_acc;
  logic        w_req;
  logic        w_busy;
  logic        w_done;
  logic        w_bubble;
  logic        w_load;
  logic [31:0] w_rd_data;
  logic [31:0] w_mem_out;

  assign w_is_ldw = (EXMemOp == C_OP_LDW);
  assign w_is_stw = (EXMemOp == C_OP_STW);
  assign w_mem_op = EXEn & (w_is_ldw | w_is_stw) & (EXExpCode == 3'd0);
  assign w_mis    = w_mem_op & (EXOut[1:0] != 2'b00);
  // An acked-but-unconsumed access must not be reissued (a store would repeat).
  assign w_acc    = w_mem_op & (EXOut[1:0] == 2'b00) & ~r_hold_valid;

  // Reset gates the request directly so the bus sees it drop without a clock.
  assign w_req    = ~reset & ((r_state == S_WAIT) | w_acc);
  assign w_busy   = w_req & ~MemAck;
  assign w_done   = w_req & MemAck;

  assign w_bubble = Flush | (r_flush_pend & MemAck);
  assign w_load   = w_bubble | (~Stall & ~w_busy);

  assign w_rd_data = r_hold_valid ? r_hold_data : MemRdData;
  assign w_mem_out = w_is_ldw ? w_rd_data :
                     w_is_stw ? 32'd0     : EXOut;

  assign MemReq    = w_req;
  assign MemWE     = w_is_stw;
  assign MemAddr   = EXOut[31:2];
  assign MemWrData = EXMemWrData;
  assign Busy      = w_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_flush_pend <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_data  <= 32'd0;
      MEMPC        <= 30'd0;
      MEMEn        <= 1'b0;
      MEMBrFlag    <= 1'b0;
      MEMCtrlOp    <= 2'd0;
      MEMDstAddr   <= 5'd0;
      MEMGPRWE_    <= 1'b1;
      MEMExpCode   <= 3'd0;
      MEMOut       <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE:  if (w_acc & ~MemAck) r_state <= S_WAIT;
        S_WAIT:  if (MemAck) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      // A flush cannot abort a bus cycle in flight; remember it until the ack.
      if (MemAck)
        r_flush_pend <= 1'b0;
      else if ((r_state == S_WAIT) & Flush)
        r_flush_pend <= 1'b1;

      if (w_load) begin
        r_hold_valid <= 1'b0;
      end else if (w_done) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= MemRdData;
      end

      if (w_bubble) begin
        MEMPC      <= 30'd0;
        MEMEn      <= 1'b0;
        MEMBrFlag  <= 1'b0;
        MEMCtrlOp  <= 2'd0;
        MEMDstAddr <= 5'd0;
        MEMGPRWE_  <= 1'b1;
        MEMExpCode <= 3'd0;
        MEMOut     <= 32'd0;
      end else if (w_load) begin
        MEMPC      <= EXPC;
        MEMEn      <= EXEn;
        MEMBrFlag  <= EXBrFlag;
        MEMCtrlOp  <= EXCtrlOp;
        MEMDstAddr <= EXDstAddr;
        MEMGPRWE_  <= EXGPRWE_ | w_mis;
        MEMExpCode <= w_mis ? C_EXC_MIS : EXExpCode;
        MEMOut     <= w_mem_out;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mem_stage                                                           |
// | Directed self-checking bench for mem_stage.                            |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset, Stall, Flush;
  logic [29:0] EXPC;
  logic        EXEn, EXBrFlag, EXGPRWE_;
  logic [1:0]  EXMemOp, EXCtrlOp;
  logic [31:0] EXMemWrData, EXOut;
  logic [4:0]  EXDstAddr;
  logic [2:0]  EXExpCode;
  logic        MemReq, MemWE, MemAck, Busy;
  logic [29:0] MemAddr;
  logic [31:0] MemWrData, MemRdData;
  logic [29:0] MEMPC;
  logic        MEMEn, MEMBrFlag, MEMGPRWE_;
  logic [1:0]  MEMCtrlOp;
  logic [4:0]  MEMDstAddr;
  logic [2:0]  MEMExpCode;
  logic [31:0] MEMOut;

  int vectors = 0;
  int miscompares = 0;

  mem_stage dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
    .EXPC(EXPC), .EXEn(EXEn), .EXBrFlag(EXBrFlag), .EXMemOp(EXMemOp),
    .EXMemWrData(EXMemWrData), .EXCtrlOp(EXCtrlOp), .EXDstAddr(EXDstAddr),
    .EXGPRWE_(EXGPRWE_), .EXExpCode(EXExpCode), .EXOut(EXOut),
    .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr), .MemWrData(MemWrData),
    .MemAck(MemAck), .MemRdData(MemRdData), .Busy(Busy),
    .MEMPC(MEMPC), .MEMEn(MEMEn), .MEMBrFlag(MEMBrFlag), .MEMCtrlOp(MEMCtrlOp),
    .MEMDstAddr(MEMDstAddr), .MEMGPRWE_(MEMGPRWE_), .MEMExpCode(MEMExpCode),
    .MEMOut(MEMOut)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ex_nop;
    EXPC = 30'd0; EXEn = 1'b0; EXBrFlag = 1'b0; EXMemOp = 2'd0;
    EXMemWrData = 32'd0; EXCtrlOp = 2'd0; EXDstAddr = 5'd0;
    EXGPRWE_ = 1'b1; EXExpCode = 3'd0; EXOut = 32'd0;
  endtask

  task automatic ex_mem(input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] dst);
    ex_nop();
    EXEn = 1'b1; EXMemOp = op; EXOut = addr; EXMemWrData = wdata;
    EXDstAddr = dst; EXGPRWE_ = (op == 2'd2); EXPC = 30'h123;
  endtask

  task automatic test_reset;
    reset = 1'b1; Stall = 1'b0; Flush = 1'b0; MemAck = 1'b0; MemRdData = 32'd0;
    ex_nop();
    tick(); tick();
    reset = 1'b0;
    tick();
    vectors++; if (MEMGPRWE_ !== 1'b1) begin miscompares++; $display("FAIL rst_gprwe got=%h exp=1", MEMGPRWE_); end
    vectors++; if (MEMEn !== 1'b0) begin miscompares++; $display("FAIL rst_en got=%h exp=0", MEMEn); end
    vectors++; if ({MEMPC, MEMBrFlag, MEMCtrlOp, MEMDstAddr, MEMExpCode, MEMOut} !== 73'd0) begin
      miscompares++; $display("FAIL rst_fields got=%h exp=0", {MEMPC, MEMBrFlag, MEMCtrlOp, MEMDstAddr, MEMExpCode, MEMOut}); end
    vectors++; if ({MemReq, Busy} !== 2'b00) begin miscompares++; $display("FAIL rst_req_busy got=%b exp=00", {MemReq, Busy}); end
  endtask

  task automatic test_zero_wait_load;
    ex_mem(2'd1, 32'h0000_0100, 32'd0, 5'd5);
    MemAck = 1'b1; MemRdData = 32'hDEAD_BEEF;
    #1;
    vectors++; if (MemAddr !== 30'h40) begin miscompares++; $display("FAIL zw_addr got=%h exp=40", MemAddr); end
    vectors++; if ({MemReq, MemWE, Busy} !== 3'b100) begin miscompares++; $display("FAIL zw_req_we_busy got=%b exp=100", {MemReq, MemWE, Busy}); end
    tick();
    ex_nop(); MemAck = 1'b0; MemRdData = 32'd0;
    #1;
    vectors++; if (MEMOut !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL zw_out got=%h exp=deadbeef", MEMOut); end
    vectors++; if ({MEMEn, MEMGPRWE_, MEMDstAddr} !== {1'b1, 1'b0, 5'd5}) begin
      miscompares++; $display("FAIL zw_en_we_dst got=%b exp=1000101", {MEMEn, MEMGPRWE_, MEMDstAddr}); end
    vectors++; if (MEMPC !== 30'h123) begin miscompares++; $display("FAIL zw_pc got=%h exp=123", MEMPC); end
    vectors++; if (MemReq !== 1'b0) begin miscompares++; $display("FAIL zw_req_drop got=%h exp=0", MemReq); end
    tick();
  endtask

  task automatic test_store_wait;
    int busy_cycles = 0;
    ex_mem(2'd2, 32'h0000_0200, 32'h1234_5678, 5'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      if (Busy === 1'b1) busy_cycles++;
      vectors++; if ({MemReq, MemWE} !== 2'b11) begin miscompares++; $display("FAIL st_req_we got=%b exp=11 cyc=%0d", {MemReq, MemWE}, i); end
      tick();
      vectors++; if (MEMEn !== 1'b0) begin miscompares++; $display("FAIL st_hold_en got=%h exp=0 cyc=%0d", MEMEn, i); end
    end
    vectors++; if (busy_cycles != 3) begin miscompares++; $display("FAIL st_busy_cycles got=%0d exp=3", busy_cycles); end
    vectors++; if ({MemAddr, MemWrData} !== {30'h80, 32'h1234_5678}) begin
      miscompares++; $display("FAIL st_addr_data got=%h exp=%h", {MemAddr, MemWrData}, {30'h80, 32'h1234_5678}); end
    MemAck = 1'b1;
    #1;
    vectors++; if ({MemReq, Busy} !== 2'b10) begin miscompares++; $display("FAIL st_ack_cycle got=%b exp=10", {MemReq, Busy}); end
    tick();
    ex_nop(); MemAck = 1'b0;
    vectors++; if ({MEMEn, MEMOut} !== {1'b1, 32'd0}) begin miscompares++; $display("FAIL st_out got=%h exp=100000000", {MEMEn, MEMOut}); end
    #1;
    vectors++; if (MemReq !== 1'b0) begin miscompares++; $display("FAIL st_req_after got=%h exp=0", MemReq); end
    tick();
  endtask

  task automatic test_misaligned;
    ex_mem(2'd1, 32'h0000_0102, 32'd0, 5'd7);
    MemAck = 1'b0;
    #1;
    vectors++; if ({MemReq, Busy} !== 2'b00) begin miscompares++; $display("FAIL mis_req got=%b exp=00", {MemReq, Busy}); end
    tick();
    ex_nop();
    vectors++; if (MEMExpCode !== 3'd4) begin miscompares++; $display("FAIL mis_exp got=%h exp=4", MEMExpCode); end
    vectors++; if ({MEMEn, MEMGPRWE_} !== 2'b11) begin miscompares++; $display("FAIL mis_en_we got=%b exp=11", {MEMEn, MEMGPRWE_}); end
    tick();
  endtask

  task automatic test_passthrough;
    ex_nop();
    EXEn = 1'b1; EXMemOp = 2'd3; EXOut = 32'hCAFE_F00D; EXBrFlag = 1'b1;
    EXCtrlOp = 2'd2; EXDstAddr = 5'd9; EXGPRWE_ = 1'b0; EXPC = 30'h2AB;
    #1;
    vectors++; if (MemReq !== 1'b0) begin miscompares++; $display("FAIL rsv_req got=%h exp=0", MemReq); end
    tick();
    vectors++; if (MEMOut !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL rsv_out got=%h exp=cafef00d", MEMOut); end
    vectors++; if ({MEMBrFlag, MEMCtrlOp, MEMDstAddr, MEMPC} !== {1'b1, 2'd2, 5'd9, 30'h2AB}) begin
      miscompares++; $display("FAIL rsv_fields got=%h exp=%h", {MEMBrFlag, MEMCtrlOp, MEMDstAddr, MEMPC}, {1'b1, 2'd2, 5'd9, 30'h2AB}); end
    ex_mem(2'd1, 32'h0000_0300, 32'd0, 5'd3);
    EXExpCode = 3'd2;
    #1;
    vectors++; if (MemReq !== 1'b0) begin miscompares++; $display("FAIL exc_req got=%h exp=0", MemReq); end
    tick();
    ex_nop();
    vectors++; if ({MEMExpCode, MEMGPRWE_} !== {3'd2, 1'b0}) begin miscompares++; $display("FAIL exc_code got=%b exp=0100", {MEMExpCode, MEMGPRWE_}); end
    tick();
  endtask

  task automatic test_flush_wait;
    ex_mem(2'd1, 32'h0000_0300, 32'd0, 5'd4);
    MemAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Flush = (i == 1);
      #1;
      vectors++; if ({MemReq, Busy} !== 2'b11) begin miscompares++; $display("FAIL fl_req got=%b exp=11 cyc=%0d", {MemReq, Busy}, i); end
      tick();
    end
    Flush = 1'b0; MemAck = 1'b1; MemRdData = 32'h1111_2222;
    #1;
    vectors++; if (MemReq !== 1'b1) begin miscompares++; $display("FAIL fl_req_ack got=%h exp=1", MemReq); end
    tick();
    ex_nop(); MemAck = 1'b0; MemRdData = 32'd0;
    vectors++; if ({MEMEn, MEMGPRWE_, MEMOut} !== {1'b0, 1'b1, 32'd0}) begin
      miscompares++; $display("FAIL fl_bubble got=%h exp=%h", {MEMEn, MEMGPRWE_, MEMOut}, {1'b0, 1'b1, 32'd0}); end
    #1;
    vectors++; if (MemReq !== 1'b0) begin miscompares++; $display("FAIL fl_idle_req got=%h exp=0", MemReq); end
    tick();
  endtask

  task automatic test_stall_hold;
    ex_mem(2'd1, 32'h0000_0600, 32'd0, 5'd6);
    MemAck = 1'b0;
    tick();
    Stall = 1'b1; MemAck = 1'b1; MemRdData = 32'h7777_8888;
    tick();
    MemAck = 1'b0; MemRdData = 32'd0;
    #1;
    vectors++; if ({MemReq, Busy} !== 2'b00) begin miscompares++; $display("FAIL hold_req got=%b exp=00", {MemReq, Busy}); end
    vectors++; if (MEMEn !== 1'b0) begin miscompares++; $display("FAIL hold_stalled got=%h exp=0", MEMEn); end
    tick();
    Stall = 1'b0;
    #1;
    vectors++; if (MemReq !== 1'b0) begin miscompares++; $display("FAIL hold_noreissue got=%h exp=0", MemReq); end
    tick();
    ex_nop();
    vectors++; if ({MEMEn, MEMOut} !== {1'b1, 32'h7777_8888}) begin miscompares++; $display("FAIL hold_out got=%h exp=177778888", {MEMEn, MEMOut}); end
    tick();
  endtask

  task automatic test_reset_wait;
    ex_nop(); EXEn = 1'b1; EXOut = 32'h5;
    tick();
    ex_mem(2'd1, 32'h0000_0400, 32'd0, 5'd8);
    MemAck = 1'b0;
    tick(); tick();
    #2;
    reset = 1'b1;
    #1;
    vectors++; if ({MemReq, Busy} !== 2'b00) begin miscompares++; $display("FAIL rw_req got=%b exp=00", {MemReq, Busy}); end
    vectors++; if ({MEMEn, MEMGPRWE_, MEMOut} !== {1'b0, 1'b1, 32'd0}) begin
      miscompares++; $display("FAIL rw_bubble got=%h exp=%h", {MEMEn, MEMGPRWE_, MEMOut}, {1'b0, 1'b1, 32'd0}); end
    tick();
    ex_nop();
    reset = 1'b0;
    #1;
    vectors++; if (MemReq !== 1'b0) begin miscompares++; $display("FAIL rw_idle got=%h exp=0", MemReq); end
    tick();
    ex_mem(2'd1, 32'h0000_0500, 32'd0, 5'd2);
    MemAck = 1'b1; MemRdData = 32'h55AA_55AA;
    #1;
    vectors++; if ({MemReq, MemAddr} !== {1'b1, 30'h140}) begin miscompares++; $display("FAIL rw_new_req got=%h exp=%h", {MemReq, MemAddr}, {1'b1, 30'h140}); end
    tick();
    ex_nop(); MemAck = 1'b0;
    vectors++; if (MEMOut !== 32'h55AA_55AA) begin miscompares++; $display("FAIL rw_new_out got=%h exp=55aa55aa", MEMOut); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [2] = '{32'h10, 32'h14};
    logic [31:0] datas [2] = '{32'hA5A5_0001, 32'h5A5A_0002};
    for (int i = 0; i < 2; i++) begin
      ex_mem(2'd1, addrs[i], 32'd0, 5'd1);
      MemAck = 1'b1; MemRdData = datas[i];
      tick();
      vectors++; if (MEMOut !== datas[i]) begin miscompares++; $display("FAIL b2b_out got=%h exp=%h idx=%0d", MEMOut, datas[i], i); end
    end
    ex_nop(); MemAck = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_zero_wait_load();
    test_store_wait();
    test_misaligned();
    test_passthrough();
    test_flush_wait();
    test_stall_hold();
    test_reset_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage sitting directly downstream of the execute stage. It consumes the EX pipeline register outputs, performs word loads and stores over a single-outstanding request/acknowledge data bus, detects misaligned accesses, and presents the MEM pipeline register to write-back. It raises Busy while a bus transaction is pending so the pipeline controller can stall the front end.

## Interface
- No parameters. Widths are fixed: word data 32, byte address 32, word address 30, register address 5, mem op 2, ctrl op 2, exception code 3.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- Stall  in  1  hold the MEM register.
- Flush  in  1  load a bubble into the MEM register.
- EXPC  in  30  PC of the instruction in EX/MEM.
- EXEn  in  1  instruction valid.
- EXBrFlag  in  1  branch-taken flag, passed through.
- EXMemOp  in  2  0 NOP, 1 LDW, 2 STW, 3 reserved (treated as NOP).
- EXMemWrData  in  32  store data.
- EXCtrlOp  in  2  control op, passed through.
- EXDstAddr  in  5  destination GPR.
- EXGPRWE_  in  1  GPR write enable, active-low.
- EXExpCode  in  3  incoming exception code; 0 means none.
- EXOut  in  32  ALU result: load/store byte address, otherwise the result value.
- MemReq  out  1  bus request.
- MemWE  out  1  1 = write, 0 = read; valid while MemReq.
- MemAddr  out  30  word address, EXOut[31:2].
- MemWrData  out  32  EXMemWrData.
- MemAck  in  1  transaction complete; may assert in the same cycle as MemReq.
- MemRdData  in  32  read data, valid with MemAck.
- Busy  out  1  access pending and not acknowledged this cycle.
- MEMPC, MEMEn, MEMBrFlag, MEMCtrlOp, MEMDstAddr, MEMGPRWE_, MEMExpCode, MEMOut  out  30/1/1/2/5/1/3/32  MEM pipeline register.

## Operation
- Access needed (Acc) = EXEn & (EXMemOp is LDW or STW) & EXExpCode==0 & EXOut[1:0]==0.
- Misaligned (Mis) = EXEn & (LDW or STW) & EXExpCode==0 & EXOut[1:0]!=0. It produces exception code 3'd4 and no bus access.
- FSM states are IDLE and WAIT.
  - IDLE: MemReq = Acc. If Acc & !MemAck, go to WAIT. If Acc & MemAck, stay in IDLE (zero-wait).
  - WAIT: MemReq = 1 and EX inputs are held by the stall. On MemAck, go to IDLE.
- Busy = MemReq & !MemAck.
- MemAddr, MemWE and MemWrData are combinational from the EX inputs. The EX inputs are stable while Busy, because the controller stalls EX.
- The MEM register loads on the rising edge when !Stall & !Busy, or when Flush.
- Flush has priority and loads a bubble: MEMEn=0, MEMGPRWE_=1, MEMBrFlag=0, MEMCtrlOp=0, MEMExpCode=0, MEMOut=0, MEMDstAddr=0, MEMPC=0.
- Normal load copies the pass-through fields, with these exceptions:
  - MEMOut = MemRdData for LDW, 0 for STW, EXOut otherwise.
  - MEMExpCode = 4 if Mis, else EXExpCode.
  - MEMGPRWE_ is forced to 1 if Mis.
  - MEMEn = EXEn.
- Flush while in WAIT cannot abort the bus.
  - Set FlushPend and keep MemReq until MemAck.
  - On MemAck, load a bubble and clear FlushPend.
  - A store still completes on the bus.
- Stall while MemAck arrives in WAIT: latch the read data in a hold register and return to IDLE. Busy drops and MemReq does not re-issue: a HoldValid flag suppresses Acc until the MEM register loads. The hold data is used for MEMOut at that load.
- Reset: state = IDLE, FlushPend = HoldValid = 0, MEM register = bubble values. MemReq drops asynchronously.

## Timing
- Zero-wait access (MemAck in the request cycle): no stall, and the MEM register loads at the same edge. Load-to-MEMOut latency is 1 cycle.
- N-cycle ack: Busy is high for N cycles, the MEM register loads at the edge ending the ack cycle, and latency is N+1.
- MemReq stays high continuously from issue until ack. There is never more than one outstanding transaction.
- Non-memory and misaligned instructions pass with 1-cycle latency and never assert MemReq.
- A reserved MemOp (3) behaves as NOP.

## Test plan
- Reset, then idle: all MEM outputs are 0 except MEMGPRWE_=1, and MemReq=0, Busy=0.
- LDW, EXOut=0x00000100, ack in the same cycle with MemRdData=0xDEADBEEF:
  - MemAddr=0x40, MemReq high for 1 cycle, Busy=0.
  - Next cycle MEMOut=0xDEADBEEF and MEMEn=1.
- STW, EXOut=0x200, EXMemWrData=0x12345678, ack after 3 cycles:
  - MemWE=1 and Busy=1 for 3 cycles.
  - MEM loads after the ack with MEMOut=0.
- LDW with EXOut=0x102: MemReq stays 0, MEMExpCode=4, MEMGPRWE_=1.
- Flush asserted in the 2nd cycle of a 4-cycle LDW wait:
  - MemReq is held until the ack.
  - The MEM register then holds a bubble (MEMEn=0).
- Reset asserted during WAIT:
  - MemReq drops the same cycle, and the FSM is in IDLE with bubble outputs.
  - After release, a new LDW issues normally.
